// File: rtl/uart_pkg.sv
// Shared constants for the UART frame parser: FSM state codes, default header bytes, bit timing.
package uart_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    localparam logic [7:0] DEF_HDR0 = 8'h55;
    localparam logic [7:0] DEF_HDR1 = 8'hAA;

    localparam int BIT_CYC  = 434;
    localparam int BYTE_CYC = 10 * BIT_CYC;

endpackage

// File: rtl/uart_word_packer.sv
// Packs payload bytes into 32-bit little-endian words and holds each word until downstream accepts it.
module uart_word_packer (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    input  logic [1:0]  lane,
    input  logic        byte_last,
    input  logic        flush,
    input  logic        out_rdy,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        out_vld,
    output logic        ovf_err
);

    logic [3:0][7:0] acc;
    logic [3:0][7:0] word;
    logic [3:0]      keep_w;
    logic            complete;
    logic            can_load;

    always_comb begin
        word       = acc;
        word[lane] = byte_data;
        keep_w     = '0;
        for (int i = 0; i < 4; i++) keep_w[i] = (i <= int'(lane));
    end

    assign complete = byte_vld && (lane == 2'd3 || byte_last);
    // An accept in this cycle frees the register for a word completing in the same cycle.
    assign can_load = !out_vld || out_rdy;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            acc      <= '0;
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
            out_vld  <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (out_vld && out_rdy) out_vld <= 1'b0;

            if (flush)          acc <= '0;
            else if (complete)  acc <= '0;
            else if (byte_vld)  acc[lane] <= byte_data;

            if (complete) begin
                if (can_load) begin
                    out_data <= word;
                    out_keep <= keep_w;
                    out_last <= byte_last;
                    out_vld  <= 1'b1;
                end else begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 LEN payload CSUM frames from a UART byte stream into 32-bit words.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] HDR0        = DEF_HDR0,
    parameter logic [7:0] HDR1        = DEF_HDR1,
    parameter int         TIMEOUT_CYC = BYTE_CYC
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_vld,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        frame_ok,
    output logic        csum_err,
    output logic        ovf_err,
    output logic        tmo_err
);

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] csum;
    logic [1:0] idx;
    logic       pay_vld;
    logic       pay_last;
    logic       flush;

    assign pay_vld  = rx_data_vld && (state == ST_PAY);
    assign pay_last = (cnt == 8'd1);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYC-th idle cycle after the last byte of an open frame.
    assign flush = (state != ST_IDLE) && !rx_data_vld
                   && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            tmo_err <= flush;
            if (state == ST_IDLE || rx_data_vld || flush) tmo_cnt <= '0;
            else                                          tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign flush   = 1'b0;
    assign tmo_err = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            csum     <= '0;
            idx      <= '0;
            frame_ok <= 1'b0;
            csum_err <= 1'b0;
        end else begin
            frame_ok <= 1'b0;
            csum_err <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else if (rx_data_vld) begin
                case (state)
                    ST_IDLE: if (rx_data == HDR0) state <= ST_HDR;
                    ST_HDR: begin
                        if (rx_data == HDR1)      state <= ST_LEN;
                        else if (rx_data != HDR0) state <= ST_IDLE;
                    end
                    ST_LEN: begin
                        if (rx_data == 8'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= rx_data;
                            csum  <= rx_data;
                            idx   <= '0;
                            state <= ST_PAY;
                        end
                    end
                    ST_PAY: begin
                        csum <= csum + rx_data;
                        cnt  <= cnt - 8'd1;
                        idx  <= idx + 2'd1;
                        if (pay_last) state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        frame_ok <= (rx_data == csum);
                        csum_err <= (rx_data != csum);
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_word_packer u_packer (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .byte_vld  (pay_vld),
        .byte_data (rx_data),
        .lane      (idx),
        .byte_last (pay_last),
        .flush     (flush),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_vld   (out_vld),
        .ovf_err   (ovf_err)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: frame-level model pushes expected words/pulses, a monitor pops them.
module tb_uart_frame_parser;
    import uart_pkg::*;

    localparam int TMO = 4340;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic [7:0]  rx_data;
    logic        rx_data_vld;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_vld;
    logic        out_rdy;
    logic        frame_ok;
    logic        csum_err;
    logic        ovf_err;
    logic        tmo_err;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t exp_w[$];
    bit    exp_ev[$];
    word_t mon_w;
    bit    mon_ev;
    int    checks = 0;
    int    passed = 0;
    bit    rand_rdy = 1'b0;
    int    rcyc = 0;

    always #5 sclk = ~sclk;

    uart_frame_parser #(
        .HDR0        (DEF_HDR0),
        .HDR1        (DEF_HDR1),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .rx_data     (rx_data),
        .rx_data_vld (rx_data_vld),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_last    (out_last),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .frame_ok    (frame_ok),
        .csum_err    (csum_err),
        .ovf_err     (ovf_err),
        .tmo_err     (tmo_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every accepted word and every checksum pulse must match the head of its queue.
    always @(negedge sclk) begin
        if (!s_rst) begin
            if (out_vld && out_rdy) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got %h/%h/%b, expected none", out_data, out_keep, out_last);
                end else begin
                    mon_w = exp_w.pop_front();
                    check("word", {out_data, out_keep, out_last}, mon_w);
                end
            end
            if (frame_ok || csum_err) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pulse: got ok=%b err=%b, expected none", frame_ok, csum_err);
                end else begin
                    mon_ev = exp_ev.pop_front();
                    check("csum_pulse", {frame_ok, csum_err}, mon_ev ? 2'b10 : 2'b01);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge sclk);
            #1;
            if (rand_rdy) begin
                rcyc++;
                // Forced high every 8 cycles so a held word never outlives the byte spacing.
                out_rdy = (rcyc % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge sclk);
        #1;
        rx_data     = b;
        rx_data_vld = 1'b1;
        @(posedge sclk);
        #1;
        rx_data_vld = 1'b0;
        repeat (gap) @(posedge sclk);
    endtask

    // csum_sel < 0 sends the correct checksum; otherwise its low byte is sent verbatim.
    task automatic send_frame(input logic [7:0] pl[$], input int csum_sel, input int gap);
        int         len;
        logic [7:0] sum;
        logic [7:0] cs;
        word_t      w;
        len = pl.size();
        sum = 8'(len);
        foreach (pl[i]) sum = sum + pl[i];
        cs = (csum_sel < 0) ? sum : 8'(csum_sel);
        for (int i = 0; i < len; i += 4) begin
            w = '0;
            for (int j = 0; j < 4 && i + j < len; j++) begin
                w.d[8*j +: 8] = pl[i+j];
                w.k[j]        = 1'b1;
            end
            w.l = (i + 4 >= len);
            exp_w.push_back(w);
        end
        exp_ev.push_back(cs == sum);
        send_byte(DEF_HDR0, gap);
        send_byte(DEF_HDR1, gap);
        send_byte(8'(len), gap);
        foreach (pl[i]) send_byte(pl[i], gap);
        send_byte(cs, gap);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_w.size() != 0 || exp_ev.size() != 0) && n < 500) begin
            @(posedge sclk);
            n++;
        end
        check(nm, exp_w.size() + exp_ev.size(), 0);
        repeat (5) @(posedge sclk);
    endtask

    task automatic do_reset();
        @(posedge sclk);
        #1;
        s_rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1;
        s_rst = 1'b0;
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] b;
        int         nj;
        s_rst       = 1'b1;
        rx_data     = '0;
        rx_data_vld = 1'b0;
        out_rdy     = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_keep", out_keep, 0);
        check("rst_out_last", out_last, 0);
        check("rst_pulses", {frame_ok, csum_err, ovf_err, tmo_err}, 0);
        s_rst = 1'b0;

        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(pl, -1, 2);
        drain("drain_4byte_ok");
        // 0x66 does not equal 04+11+22+33+44 = 0xAE, so this one must flag csum_err.
        send_frame(pl, 8'h66, 2);
        drain("drain_4byte_bad");

        pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(pl, 8'h14, 1);
        drain("drain_5byte");

        pl = {8'h7F};
        send_frame(pl, 8'h00, 1);
        drain("drain_1byte_err");

        send_byte(DEF_HDR0, 1);
        pl = {8'h10};
        send_frame(pl, 8'h11, 1);
        drain("drain_double_hdr0");
        send_byte(DEF_HDR0, 1);
        send_byte(DEF_HDR1, 1);
        send_byte(8'h00, 1);
        pl = {8'hA5, 8'h5A};
        send_frame(pl, -1, 1);
        drain("drain_after_len0");

        send_byte(DEF_HDR0, 1);
        send_byte(DEF_HDR1, 1);
        send_byte(8'h04, 1);
        send_byte(8'h11, 1);
        do_reset();
        check("midrst_out_vld", out_vld, 0);
        foreach (pl[i]) pl.delete(i);
        pl = {8'hAA, 8'h02, 8'h01, 8'h02, 8'h03};
        foreach (pl[i]) send_byte(pl[i], 1);
        pl = {8'hDE, 8'hAD, 8'hBE};
        send_frame(pl, -1, 1);
        drain("drain_after_midrst");

        rand_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom);
                if (b == DEF_HDR0) b = 8'h00;
                send_byte(b, 9);
            end
            pl = {};
            for (int j = 0; j < int'($urandom_range(1, 12)); j++) pl.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) send_frame(pl, $urandom_range(0, 255), $urandom_range(9, 12));
            else                           send_frame(pl, -1, $urandom_range(9, 12));
        end
        drain("drain_random");
        check("random_no_ovf", ovf_err, 0);
        rand_rdy = 1'b0;
        #1;
        out_rdy = 1'b1;

        pl = {};
        for (int j = 0; j < 255; j++) pl.push_back(8'($urandom));
        send_frame(pl, -1, 0);
        drain("drain_len255");

        out_rdy = 1'b0;
        pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(pl, -1, 2);
        // Output held throughout, so every word after the first is lost.
        while (exp_w.size() > 1) void'(exp_w.pop_back());
        @(negedge sclk);
        check("ovf_held_vld", out_vld, 1);
        check("ovf_held_word", {out_data, out_keep, out_last}, {32'h04030201, 4'hF, 1'b0});
        check("ovf_flag", ovf_err, 1);
        @(posedge sclk);
        #1;
        out_rdy = 1'b1;
        drain("drain_ovf");
        check("ovf_sticky", ovf_err, 1);
        do_reset();
        check("ovf_cleared", ovf_err, 0);

`ifdef UART_FRAME_TIMEOUT_EN
        begin
            int tmo_n = 0;
            int vld_n = 0;
            send_byte(DEF_HDR0, 0);
            send_byte(DEF_HDR1, 0);
            send_byte(8'h03, 0);
            send_byte(8'h01, 0);
            repeat (TMO + 10) begin
                @(negedge sclk);
                if (tmo_err) tmo_n++;
                if (out_vld) vld_n++;
            end
            check("tmo_pulses", tmo_n, 1);
            check("tmo_no_out", vld_n, 0);
            pl = {8'h21, 8'h43};
            send_frame(pl, -1, 1);
            drain("drain_after_tmo");
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
